// File: rtl/recibir_trama.sv
// rtl/recibir_trama.sv - serial frame receiver: start, 14 data bits LSB first, parity, stop
module recibir_trama #(
    parameter int CICLOS_BIT  = 16,
    parameter int PARIDAD_PAR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [13:0] data,
    output logic        enable,
    output logic        error_trama,
    output logic        ocupado
);

    localparam int W_CNT = $clog2(CICLOS_BIT);
    localparam logic [W_CNT-1:0] CNT_MEDIO = W_CNT'(CICLOS_BIT / 2 - 1);
    localparam logic [W_CNT-1:0] CNT_BIT   = W_CNT'(CICLOS_BIT - 1);
    // Expected XOR over data plus parity bit: 0 for even parity, 1 for odd
    localparam logic PAR_OBJETIVO = (PARIDAD_PAR != 0) ? 1'b0 : 1'b1;

    typedef enum logic [2:0] {
        REPOSO,
        INICIO,
        DATOS,
        PARIDAD,
        PARADA,
        ESPERA
    } estado_t;

    logic             r_rx_meta;
    logic             r_rx_s;
    estado_t          r_estado;
    logic [W_CNT-1:0] r_cnt;
    logic [3:0]       r_idx;
    logic [13:0]      r_shift;
    logic             r_par;
    logic [13:0]      r_data;
    logic             r_enable;
    logic             r_error;

    logic             w_fin_medio;
    logic             w_fin_bit;
    logic             w_paridad_ok;

    assign w_fin_medio  = (r_cnt == CNT_MEDIO);
    assign w_fin_bit    = (r_cnt == CNT_BIT);
    assign w_paridad_ok = (((^r_shift) ^ r_par) == PAR_OBJETIVO);

    assign data        = r_data;
    assign enable      = r_enable;
    assign error_trama = r_error;
    assign ocupado     = (r_estado != REPOSO);

    // Two-flop synchronizer; idle line is high so the flops reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame FSM: samples mid-bit, result pulses are registered one-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= REPOSO;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_data   <= '0;
            r_enable <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_enable <= 1'b0;
            r_error  <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_estado <= INICIO;
                    end
                end
                INICIO: begin
                    if (w_fin_medio) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        // A line that is high again at mid-start was only a glitch
                        r_estado <= r_rx_s ? REPOSO : DATOS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATOS: begin
                    if (w_fin_bit) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[13:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == 4'd13) begin
                            r_estado <= PARIDAD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PARIDAD: begin
                    if (w_fin_bit) begin
                        r_cnt    <= '0;
                        r_par    <= r_rx_s;
                        r_estado <= PARADA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PARADA: begin
                    if (w_fin_bit) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_estado <= REPOSO;
                            if (w_paridad_ok) begin
                                r_data   <= r_shift;
                                r_enable <= 1'b1;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end else begin
                            // Broken stop bit: wait for the line to go idle before rearming
                            r_error  <= 1'b1;
                            r_estado <= ESPERA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ESPERA: begin
                    r_cnt <= '0;
                    if (r_rx_s) begin
                        r_estado <= REPOSO;
                    end
                end
                default: begin
                    r_estado <= REPOSO;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_recibir_trama.sv
// tb/tb_recibir_trama.sv - self-checking bench for recibir_trama
module tb_recibir_trama;

    localparam int CB = 16;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [13:0] data;
    logic        enable;
    logic        error_trama;
    logic        ocupado;

    recibir_trama #(.CICLOS_BIT(CB), .PARIDAD_PAR(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .data        (data),
        .enable      (enable),
        .error_trama (error_trama),
        .ocupado     (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] d;
        logic        p;
        logic        s;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        is_err;
        logic [13:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [13:0] last_good;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [13:0] d, input logic err);
        exp_t e;
        e.is_err = err;
        e.data   = err ? last_good : d;
        exp_q.push_back(e);
        if (!err) last_good = d;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [13:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 14; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard side: every result pulse must match the oldest pending expectation
    logic        prev_en;
    logic        prev_err;
    logic [13:0] prev_data;
    initial begin
        prev_en   = 1'b0;
        prev_err  = 1'b0;
        prev_data = '0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_data = data;
            prev_en   = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (data !== prev_data && enable !== 1'b1) begin
                n_bad++;
                $display("FAIL data_sin_enable: got %0h expected %0h", data, prev_data);
            end
            if (enable || error_trama) begin
                check("exclusivos", {31'd0, enable & error_trama}, 32'd0);
                check("ancho_pulso", {31'd0, (enable & prev_en) | (error_trama & prev_err)}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pulso_inesperado: got en=%0b err=%0b expected none", enable, error_trama);
                end else begin
                    e = exp_q.pop_front();
                    check("tipo_pulso", {31'd0, error_trama}, {31'd0, e.is_err});
                    check("data_pulso", {18'd0, data}, {18'd0, e.data});
                end
            end
            prev_data = data;
            prev_en   = enable;
            prev_err  = error_trama;
        end
    end

    vec_t tabla[10];

    initial begin
        logic [16:0] f;
        int          k;
        n_cmp     = 0;
        n_bad     = 0;
        last_good = '0;

        tabla[0] = '{14'h014A, 1'b0, 1'b1, 1'b0};
        tabla[1] = '{14'h014F, 1'b0, 1'b1, 1'b0};
        tabla[2] = '{14'h014A, 1'b1, 1'b1, 1'b1};
        tabla[3] = '{14'h3FFF, 1'b0, 1'b1, 1'b0};
        tabla[4] = '{14'h2AAA, 1'b1, 1'b1, 1'b0};
        tabla[5] = '{14'h0000, 1'b0, 1'b1, 1'b0};
        tabla[6] = '{14'h0001, 1'b1, 1'b1, 1'b0};
        tabla[7] = '{14'h1234, 1'b1, 1'b1, 1'b0};
        tabla[8] = '{14'h2000, 1'b0, 1'b1, 1'b1};
        tabla[9] = '{14'h1234, 1'b1, 1'b0, 1'b1};

        // Reset state
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", {18'd0, data}, 32'd0);
        check("rst_enable", {31'd0, enable}, 32'd0);
        check("rst_error", {31'd0, error_trama}, 32'd0);
        check("rst_ocupado", {31'd0, ocupado}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Table of single frames separated by idle time
        for (int i = 0; i < 10; i++) begin
            push_exp(tabla[i].d, tabla[i].exp_err);
            send_frame(tabla[i].d, tabla[i].p, tabla[i].s);
            idle(20);
            check("tabla_pendientes", exp_q.size(), 32'd0);
            check("tabla_ocupado", {31'd0, ocupado}, 32'd0);
            check("tabla_data", {18'd0, data}, {18'd0, last_good});
        end

        // Back-to-back frames, no idle bits between them
        push_exp(14'h014A, 1'b0);
        send_frame(14'h014A, 1'b0, 1'b1);
        push_exp(14'h014F, 1'b0);
        send_frame(14'h014F, 1'b0, 1'b1);
        idle(20);
        check("b2b_pendientes", exp_q.size(), 32'd0);
        check("b2b_data", {18'd0, data}, 32'h014F);

        // Stop bit 0 with the line held low afterwards
        push_exp(14'h0001, 1'b1);
        send_frame(14'h0001, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        check("espera_ocupado", {31'd0, ocupado}, 32'd1);
        check("espera_pendientes", exp_q.size(), 32'd0);
        rx = 1'b1;
        for (k = 0; k < 5 && ocupado; k++) @(negedge clk);
        check("espera_libera", {31'd0, ocupado}, 32'd0);
        idle(4);
        push_exp(14'h3FFF, 1'b0);
        send_frame(14'h3FFF, 1'b0, 1'b1);
        idle(20);
        check("tras_espera_pendientes", exp_q.size(), 32'd0);
        check("tras_espera_data", {18'd0, data}, 32'h3FFF);

        // False start: four low cycles only
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        for (k = 0; k < CB / 2 + 3 && ocupado; k++) @(negedge clk);
        check("falso_inicio_ocupado", {31'd0, ocupado}, 32'd0);
        idle(10);
        check("falso_inicio_data", {18'd0, data}, 32'h3FFF);

        // Reset asserted in the middle of data bit 7
        f = {1'b1, 1'b0, 14'h014A};
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(f[i]);
        rx = f[7];
        repeat (5) @(negedge clk);
        check("pre_rst_ocupado", {31'd0, ocupado}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_data", {18'd0, data}, 32'd0);
        check("rst_async_enable", {31'd0, enable}, 32'd0);
        check("rst_async_error", {31'd0, error_trama}, 32'd0);
        check("rst_async_ocupado", {31'd0, ocupado}, 32'd0);
        last_good = '0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        push_exp(14'h2AAA, 1'b0);
        send_frame(14'h2AAA, 1'b1, 1'b1);
        idle(20);
        check("post_rst_pendientes", exp_q.size(), 32'd0);
        check("post_rst_data", {18'd0, data}, 32'h2AAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
